// File: rtl/unidade_de_escrita.sv
// Register-file write-back queue: in-order DEPTH-entry buffer draining one write per cycle.
// Optional pending-write bypass lookup enabled by defining ESCRITA_BYPASS_EN.
module unidade_de_escrita #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     ew_in_clk,
    input  logic                     ew_in_rst,
    input  logic                     ew_in_valid,
    output logic                     ew_out_ready,
    input  logic [ADDR_W-1:0]        ew_in_rd,
    input  logic [DATA_W-1:0]        ew_in_data,
    input  logic                     ew_in_flush,
    output logic                     ew_out_we,
    output logic [ADDR_W-1:0]        ew_out_rd,
    output logic [DATA_W-1:0]        ew_out_data,
    input  logic                     ew_in_wr_ready,
    output logic [$clog2(DEPTH):0]   ew_out_count,
    input  logic [ADDR_W-1:0]        ew_in_rs,
    input  logic [ADDR_W-1:0]        ew_in_rt,
    output logic                     ew_out_hit_rs,
    output logic                     ew_out_hit_rt,
    output logic [DATA_W-1:0]        ew_out_fwd_rs,
    output logic [DATA_W-1:0]        ew_out_fwd_rt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [ADDR_W-1:0] mem_rd_q   [DEPTH];
    logic [DATA_W-1:0] mem_data_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic push, enq, pop;

    assign ew_out_ready = (count_q != CW'(DEPTH)) && !ew_in_flush;
    assign push         = ew_in_valid && ew_out_ready;
    // Register zero is never written, so such requests are accepted and dropped.
    assign enq          = push && (ew_in_rd != '0);
    assign ew_out_we    = (count_q != '0);
    assign pop          = ew_out_we && ew_in_wr_ready;

    assign ew_out_rd    = ew_out_we ? mem_rd_q[head_q]   : '0;
    assign ew_out_data  = ew_out_we ? mem_data_q[head_q] : '0;
    assign ew_out_count = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (ew_in_flush) begin
            // A pop in the flush cycle is not counted; everything is discarded.
            count_d = '0;
            head_d  = tail_q;
        end else begin
            if (pop) head_d = head_q + PW'(1);
            if (enq) tail_d = tail_q + PW'(1);
            case ({enq, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge ew_in_clk) begin
        if (ew_in_rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge ew_in_clk) begin
        if (enq && !ew_in_rst) begin
            mem_rd_q[tail_q]   <= ew_in_rd;
            mem_data_q[tail_q] <= ew_in_data;
        end
    end

`ifdef ESCRITA_BYPASS_EN
    // Scan oldest to youngest so the youngest matching entry wins.
    function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] key);
        logic [DATA_W:0] res;
        logic [PW-1:0]   idx;
        res = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (key != '0) && (mem_rd_q[idx] == key)) begin
                res = {1'b1, mem_data_q[idx]};
            end
        end
        return res;
    endfunction

    assign {ew_out_hit_rs, ew_out_fwd_rs} = lookup(ew_in_rs);
    assign {ew_out_hit_rt, ew_out_fwd_rt} = lookup(ew_in_rt);
`else
    logic unused_lookup;
    assign unused_lookup = ^{ew_in_rs, ew_in_rt};
    assign ew_out_hit_rs = 1'b0;
    assign ew_out_hit_rt = 1'b0;
    assign ew_out_fwd_rs = '0;
    assign ew_out_fwd_rt = '0;
`endif

endmodule

// File: tb/tb_unidade_de_escrita.sv
// Bench for unidade_de_escrita: queue-based reference model plus directed and random traffic.
module tb_unidade_de_escrita;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst, valid, ready, flush, we, wr_ready;
    logic [4:0]  rd, out_rd, rs, rt;
    logic [31:0] data, out_data, fwd_rs, fwd_rt;
    logic [2:0]  count;
    logic        hit_rs, hit_rt;

    unidade_de_escrita dut (
        .ew_in_clk      (clk),
        .ew_in_rst      (rst),
        .ew_in_valid    (valid),
        .ew_out_ready   (ready),
        .ew_in_rd       (rd),
        .ew_in_data     (data),
        .ew_in_flush    (flush),
        .ew_out_we      (we),
        .ew_out_rd      (out_rd),
        .ew_out_data    (out_data),
        .ew_in_wr_ready (wr_ready),
        .ew_out_count   (count),
        .ew_in_rs       (rs),
        .ew_in_rt       (rt),
        .ew_out_hit_rs  (hit_rs),
        .ew_out_hit_rt  (hit_rt),
        .ew_out_fwd_rs  (fwd_rs),
        .ew_out_fwd_rt  (fwd_rt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: plain queues of pending writes, oldest first.
    logic [4:0]  m_rd[$];
    logic [31:0] m_data[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_lookup(input logic [4:0] key, output logic hit, output logic [31:0] fwd);
        hit = 1'b0;
        fwd = '0;
`ifdef ESCRITA_BYPASS_EN
        if (key != 0) begin
            for (int i = m_rd.size() - 1; i >= 0; i--) begin
                if (m_rd[i] == key) begin
                    hit = 1'b1;
                    fwd = m_data[i];
                    break;
                end
            end
        end
`endif
    endtask

    task automatic compare_model();
        logic        e_hit;
        logic [31:0] e_fwd;
        chk("ready", {31'b0, ready}, {31'b0, (m_rd.size() != DEPTH) && !flush});
        chk("we", {31'b0, we}, {31'b0, m_rd.size() != 0});
        chk("count", {29'b0, count}, m_rd.size());
        chk("out_rd", {27'b0, out_rd}, m_rd.size() != 0 ? {27'b0, m_rd[0]} : 32'd0);
        chk("out_data", out_data, m_rd.size() != 0 ? m_data[0] : 32'd0);
        model_lookup(rs, e_hit, e_fwd);
        chk("hit_rs", {31'b0, hit_rs}, {31'b0, e_hit});
        chk("fwd_rs", fwd_rs, e_fwd);
        model_lookup(rt, e_hit, e_fwd);
        chk("hit_rt", {31'b0, hit_rt}, {31'b0, e_hit});
        chk("fwd_rt", fwd_rt, e_fwd);
    endtask

    // Apply inputs for one cycle away from the clock edge, then check the model.
    task automatic drive(input logic i_rst, input logic i_valid, input logic [4:0] i_rd,
                         input logic [31:0] i_data, input logic i_wr, input logic i_flush,
                         input logic [4:0] i_rs, input logic [4:0] i_rt);
        @(negedge clk);
        rst      = i_rst;
        valid    = i_valid;
        rd       = i_rd;
        data     = i_data;
        wr_ready = i_wr;
        flush    = i_flush;
        rs       = i_rs;
        rt       = i_rt;
        #1;
        if (!rst) compare_model();
    endtask

    task automatic tick();
        logic do_pop, do_push;
        @(posedge clk);
        if (rst || flush) begin
            m_rd.delete();
            m_data.delete();
        end else begin
            do_pop  = (m_rd.size() != 0) && wr_ready;
            do_push = valid && (m_rd.size() != DEPTH) && (rd != 0);
            if (do_pop) begin
                void'(m_rd.pop_front());
                void'(m_data.pop_front());
            end
            if (do_push) begin
                m_rd.push_back(rd);
                m_data.push_back(data);
            end
        end
    endtask

    task automatic idle(input logic i_wr);
        drive(1'b0, 1'b0, 5'd0, 32'd0, i_wr, 1'b0, 5'd0, 5'd0);
    endtask

    task automatic push(input logic [4:0] i_rd, input logic [31:0] i_data, input logic i_wr);
        drive(1'b0, 1'b1, i_rd, i_data, i_wr, 1'b0, 5'd0, 5'd0);
        tick();
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; rd = '0; data = '0; wr_ready = 1'b0;
        flush = 1'b0; rs = '0; rt = '0;

        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        tick();
        idle(1'b0);
        chk("rst_we", {31'b0, we}, 32'd0);
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_count", {29'b0, count}, 32'd0);
        chk("rst_rd", {27'b0, out_rd}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_hit", {30'b0, hit_rs, hit_rt}, 32'd0);
        tick();

        // Single write, one-cycle latency.
        push(5'd8, 32'h0000_00AA, 1'b1);
        idle(1'b1);
        chk("single_we", {31'b0, we}, 32'd1);
        chk("single_rd", {27'b0, out_rd}, 32'd8);
        chk("single_data", out_data, 32'hAA);
        tick();
        idle(1'b1);
        chk("single_done_we", {31'b0, we}, 32'd0);
        chk("single_done_count", {29'b0, count}, 32'd0);
        tick();

        // Fill under back-pressure, then drain in order.
        for (int k = 1; k <= 4; k++) push(5'(k), 32'h11 * k, 1'b0);
        drive(1'b0, 1'b1, 5'd5, 32'h55, 1'b0, 1'b0, 5'd0, 5'd0);
        chk("full_count", {29'b0, count}, 32'd4);
        chk("full_ready", {31'b0, ready}, 32'd0);
        tick();
        for (int k = 1; k <= 4; k++) begin
            idle(1'b1);
            chk("drain_rd", {27'b0, out_rd}, k);
            chk("drain_data", out_data, 32'h11 * k);
            chk("drain_ready", {31'b0, ready}, (k == 1) ? 32'd0 : 32'd1);
            tick();
        end
        idle(1'b1);
        chk("drained_we", {31'b0, we}, 32'd0);
        tick();

        // Register zero is accepted but dropped.
        drive(1'b0, 1'b1, 5'd0, 32'hDEAD, 1'b1, 1'b0, 5'd0, 5'd0);
        chk("r0_ready", {31'b0, ready}, 32'd1);
        tick();
        idle(1'b1);
        chk("r0_count", {29'b0, count}, 32'd0);
        chk("r0_we", {31'b0, we}, 32'd0);
        tick();

        // Bypass: youngest write to the same register wins.
        push(5'd9, 32'h5, 1'b0);
        push(5'd9, 32'h7, 1'b0);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd9, 5'd0);
`ifdef ESCRITA_BYPASS_EN
        chk("byp_hit_rs", {31'b0, hit_rs}, 32'd1);
        chk("byp_fwd_rs", fwd_rs, 32'h7);
`else
        chk("byp_hit_rs", {31'b0, hit_rs}, 32'd0);
        chk("byp_fwd_rs", fwd_rs, 32'd0);
`endif
        chk("byp_hit_rt", {31'b0, hit_rt}, 32'd0);
        chk("byp_fwd_rt", fwd_rt, 32'd0);
        tick();
        idle(1'b1); tick();
        idle(1'b1); tick();

        // Flush with a same-cycle push.
        for (int k = 0; k < 3; k++) push(5'(k + 3), 32'hA0 + k, 1'b0);
        drive(1'b0, 1'b1, 5'd20, 32'hBEEF, 1'b0, 1'b1, 5'd0, 5'd0);
        chk("flush_ready", {31'b0, ready}, 32'd0);
        chk("flush_we", {31'b0, we}, 32'd1);
        tick();
        idle(1'b0);
        chk("post_flush_count", {29'b0, count}, 32'd0);
        chk("post_flush_we", {31'b0, we}, 32'd0);
        tick();

        // Reset mid-operation.
        push(5'd6, 32'h66, 1'b0);
        push(5'd7, 32'h77, 1'b0);
        drive(1'b1, 1'b1, 5'd8, 32'h88, 1'b1, 1'b0, 5'd0, 5'd0);
        tick();
        idle(1'b0);
        chk("mid_rst_count", {29'b0, count}, 32'd0);
        chk("mid_rst_we", {31'b0, we}, 32'd0);
        tick();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(99) == 0, $urandom_range(9) < 7, 5'($urandom_range(7)),
                  $urandom, $urandom_range(1) == 1, $urandom_range(39) == 0,
                  5'($urandom_range(7)), 5'($urandom_range(7)));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
